// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional build macro UART_ARB_PRIO0_EN: requester 0 takes absolute priority at packet boundaries.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       TxD_busy,
    output logic                       TxD_start,
    output logic [7:0]                 TxD_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       locked,
    output logic                       timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [IDW-1:0]     LP_ID_LAST = IDW'(NUM_REQ - 1);
    localparam logic [CW-1:0]      LP_CNT_MAX = CW'(BUSY_TIMEOUT);
    localparam logic [NUM_REQ-1:0] LP_ONE_HOT = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_start;
    logic [7:0]       r_data;
    logic [IDW-1:0]   r_grant;
    logic             r_locked;
    logic             r_terr;
    logic             r_last;
    logic [IDW-1:0]   r_ptr;
    logic [CW-1:0]    r_cnt;

    logic             w_start_nxt;
    logic [7:0]       w_data_nxt;
    logic [IDW-1:0]   w_grant_nxt;
    logic             w_locked_nxt;
    logic             w_terr_nxt;
    logic             w_last_nxt;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [CW-1:0]    w_cnt_nxt;

    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic [IDW-1:0]   w_idx;
    logic             w_hit;
    logic             w_accept;
    logic             w_timeout;
    logic [IDW-1:0]   w_ptr_rel;
    logic [7:0]       w_sel_data;

    function automatic logic [IDW-1:0] f_next_id(input logic [IDW-1:0] v);
        f_next_id = (v == LP_ID_LAST) ? {IDW{1'b0}} : v + IDW'(1'b1);
    endfunction

    // Arbitration: locked packets keep their owner, otherwise search upward from pointer+1.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_grant;
        w_idx    = r_ptr;
        w_hit    = 1'b0;
        if (r_locked) begin
            w_found  = req_valid[r_grant];
            w_winner = r_grant;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx    = f_next_id(w_idx);
                w_hit    = req_valid[w_idx] & ~w_found;
                w_found  = w_found | w_hit;
                w_winner = w_hit ? w_idx : w_winner;
            end
`ifdef UART_ARB_PRIO0_EN
            w_found  = w_found | req_valid[0];
            w_winner = req_valid[0] ? {IDW{1'b0}} : w_winner;
`endif
        end
    end

    assign w_accept   = (r_state == ST_IDLE) & ~TxD_busy & w_found & ~reset;
    assign w_timeout  = (r_state == ST_SEND) & ~TxD_busy & (r_cnt == LP_CNT_MAX);
    assign w_sel_data = req_data[{w_winner, 3'b000} +: 8];

`ifdef UART_ARB_PRIO0_EN
    // A requester-0 packet leaves the round-robin position untouched.
    assign w_ptr_rel = (r_grant == {IDW{1'b0}}) ? r_ptr : r_grant;
`else
    assign w_ptr_rel = r_grant;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (TxD_busy) begin
                    w_state_nxt = ST_WAIT;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (!TxD_busy) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values; req_ready is the only combinational output.
    always_comb begin
        w_start_nxt  = r_start;
        w_data_nxt   = r_data;
        w_grant_nxt  = r_grant;
        w_locked_nxt = r_locked;
        w_terr_nxt   = 1'b0;
        w_last_nxt   = r_last;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        req_ready    = w_accept ? (LP_ONE_HOT << w_winner) : {NUM_REQ{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_data_nxt   = w_sel_data;
                    w_grant_nxt  = w_winner;
                    w_locked_nxt = 1'b1;
                    w_last_nxt   = req_last[w_winner];
                    w_start_nxt  = 1'b1;
                    w_cnt_nxt    = {CW{1'b0}};
                end else begin
                    w_start_nxt  = 1'b0;
                    w_cnt_nxt    = {CW{1'b0}};
                end
            end
            ST_SEND: begin
                if (TxD_busy) begin
                    w_start_nxt  = 1'b0;
                    w_cnt_nxt    = {CW{1'b0}};
                end else if (w_timeout) begin
                    // Transmitter never answered: drop the rest of this packet.
                    w_start_nxt  = 1'b0;
                    w_terr_nxt   = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_ptr_nxt    = w_ptr_rel;
                    w_cnt_nxt    = {CW{1'b0}};
                end else begin
                    w_cnt_nxt    = r_cnt + CW'(1'b1);
                end
            end
            ST_WAIT: begin
                if (!TxD_busy && r_last) begin
                    w_locked_nxt = 1'b0;
                    w_ptr_nxt    = w_ptr_rel;
                end else begin
                    w_locked_nxt = r_locked;
                end
            end
            default: begin
                w_start_nxt  = 1'b0;
                w_locked_nxt = 1'b0;
                w_cnt_nxt    = {CW{1'b0}};
            end
        endcase
    end

    // Registered outputs, packet bookkeeping and busy-timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start  <= 1'b0;
            r_data   <= 8'h00;
            r_grant  <= {IDW{1'b0}};
            r_locked <= 1'b0;
            r_terr   <= 1'b0;
            r_last   <= 1'b0;
            r_ptr    <= LP_ID_LAST;
            r_cnt    <= {CW{1'b0}};
        end else begin
            r_start  <= w_start_nxt;
            r_data   <= w_data_nxt;
            r_grant  <= w_grant_nxt;
            r_locked <= w_locked_nxt;
            r_terr   <= w_terr_nxt;
            r_last   <= w_last_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign TxD_start   = r_start;
    assign TxD_data    = r_data;
    assign grant_id    = r_grant;
    assign locked      = r_locked;
    assign timeout_err = r_terr;

endmodule
